ob_match: RTL and testbench
===========================

# ob_match

Price-matching stage directly downstream of the bid and ask `ob_table` instances. It watches both table heads and detects a cross (best bid ≥ best ask). On a cross it emits one trade over a valid/accept handshake. It then writes the residual quantity back into each head, or pops any head that is fully filled, and repeats until the book no longer crosses.

## Interface
- `CNT_W`, default 32: width of the saturating trade counter.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `match_en` in 1: permits new match attempts; sampled only in IDLE.
- `bid_head_vld_r` in 1: bid table head is valid.
- `bid_head_r` in `ob_pkg::table_t`: bid head entry (`uid`, `quantity`, `price`).
- `ask_head_vld_r` in 1: ask table head is valid.
- `ask_head_r` in `ob_pkg::table_t`: ask head entry.
- `bid_head_pop` out 1: remove the bid head (fully filled).
- `bid_head_upt` out 1: overwrite the bid head.
- `bid_head_upt_tbl` out `ob_pkg::table_t`: bid head write data.
- `ask_head_pop`, `ask_head_upt`, `ask_head_upt_tbl`: same as the bid signals, for the ask table.
- `trade_vld_r` out 1: a trade is presented.
- `trade_r` out `ob_pkg::trade_t`: `bid_uid`, `ask_uid`, `quantity`, `price`.
- `trade_accept` in 1: consumer takes the trade.
- `busy_r` out 1: matcher owns the table heads; upstream must hold insert/delete low while this is high.
- `trade_cnt_r` out `CNT_W`: number of trades accepted since reset; saturates at all-ones.

## Operation
- FSM states: IDLE, CMP, EMIT, UPDATE, SETTLE.
- IDLE → CMP when `match_en` is high. `busy_r` rises on entry to CMP.
- CMP checks for a cross: `bid_head_vld_r & ask_head_vld_r & (bid.price >= ask.price)`, using BCD-ordered unsigned compare.
  - No cross → IDLE.
  - Cross → latch the trade and go to EMIT.
- Trade fields:
  - `quantity` = min(bid.quantity, ask.quantity).
  - `price` = ask.price (resting ask price).
  - `bid_uid` and `ask_uid` are copied from the heads.
  - Residuals are computed as `bid.quantity - q` and `ask.quantity - q`; they never underflow.
- EMIT holds `trade_vld_r` high and `trade_r` stable until the cycle in which `trade_accept` is high; that cycle → UPDATE.
  - `trade_accept` while `trade_vld_r` is low is ignored.
- UPDATE is a single cycle. Per side:
  - residual == 0 → pulse `*_head_pop`.
  - otherwise → pulse `*_head_upt`, with `*_head_upt_tbl` = head copy whose quantity is the residual.
  - `pop` and `upt` are never both high on the same side. Both sides may pop in the same cycle (equal quantities).
  - `trade_cnt_r` increments in this cycle, saturating.
- SETTLE lasts exactly one cycle, letting the table head flops reflect the update. Then:
  - `match_en` high → CMP.
  - `match_en` low → IDLE.
- `busy_r` is high in CMP, EMIT, UPDATE and SETTLE, and low in IDLE.
- Zero-quantity heads are never produced by this block. A zero-quantity crossing head still trades with q=0 and is popped.

## Timing
- Reset: state IDLE.
  - Outputs low: `trade_vld_r`, `busy_r`, all pops/upts.
  - `trade_cnt_r` = 0, `trade_r` = 0.
- Pop/upt strobes are combinational from the state register, high only in UPDATE. `*_head_upt_tbl` is 0 outside UPDATE.
- Minimum trade period: CMP, EMIT (accepted in first cycle), UPDATE, SETTLE = 4 cycles.
- Latency:
  - From `match_en` high in IDLE, `trade_vld_r` rises 2 cycles later.
  - From accept, the pop/upt strobe fires on the next cycle.
- `rst` mid-EMIT drops `trade_vld_r` on the next cycle. The trade is lost and no table update is issued.
- `match_en` deassertion mid-sequence does not abort; the current trade completes.
- `trade_cnt_r` at all-ones stays at all-ones.

## Structure
- Add to `ob_pkg`:
  - `quantity_t`, if not already present.
  - `trade_t`.
  - `match_state_t` enum.
- The min/residual arithmetic is inline. No sub-module.

## Test plan
- Bid 105/qty 10 vs ask 100/qty 4, accept immediate → trade {q=4, price=100}; ask pop; bid upt qty 6; `trade_cnt_r`=1.
- Equal quantities: bid 100/5 vs ask 100/5 → trade q=5; both pops in the same cycle; next CMP sees the new heads.
- No cross: bid 99 vs ask 100, `match_en` high → `trade_vld_r` never rises; FSM cycles CMP→IDLE.
- Back-pressure: hold `trade_accept` low 7 cycles → `trade_r` stable; no pop/upt until the cycle after accept.
- Multi-level sweep: bid 110/12 against asks 100/3, 102/4, 105/10 → three trades (3, 4, 5); bid popped on the third trade; ask 105 residual 5.
- Reset asserted during EMIT → all outputs return to reset values in one cycle; `trade_cnt_r`=0; no strobes issued.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types: table entries, trade records and matcher state encoding.
package ob_pkg;

    localparam int unsigned UID_W   = 16;
    localparam int unsigned QTY_W   = 16;
    localparam int unsigned PRICE_W = 16;

    typedef logic [UID_W-1:0]   uid_t;
    typedef logic [QTY_W-1:0]   quantity_t;
    // Prices are BCD digits; BCD ordering coincides with plain unsigned ordering.
    typedef logic [PRICE_W-1:0] price_t;

    typedef struct packed {
        uid_t      uid;
        quantity_t quantity;
        price_t    price;
    } table_t;

    typedef struct packed {
        uid_t      bid_uid;
        uid_t      ask_uid;
        quantity_t quantity;
        price_t    price;
    } trade_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_EMIT,
        ST_UPDATE,
        ST_SETTLE
    } match_state_t;

    function automatic quantity_t qty_min(input quantity_t a, input quantity_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ob_match.sv
// Matches crossing bid/ask table heads, emits one trade per cross and writes
// residuals back (or pops filled heads) until the book no longer crosses.
module ob_match
    import ob_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             match_en,
    input  logic             bid_head_vld_r,
    input  table_t           bid_head_r,
    input  logic             ask_head_vld_r,
    input  table_t           ask_head_r,
    output logic             bid_head_pop,
    output logic             bid_head_upt,
    output table_t           bid_head_upt_tbl,
    output logic             ask_head_pop,
    output logic             ask_head_upt,
    output table_t           ask_head_upt_tbl,
    output logic             trade_vld_r,
    output trade_t           trade_r,
    input  logic             trade_accept,
    output logic             busy_r,
    output logic [CNT_W-1:0] trade_cnt_r
);

    match_state_t state_q;
    match_state_t state_d;

    logic      cross_c;
    quantity_t fill_qty_c;
    quantity_t bid_res_r;
    quantity_t ask_res_r;

    // Cross detection and fill size from the live heads.
    assign cross_c    = bid_head_vld_r & ask_head_vld_r &
                        (bid_head_r.price >= ask_head_r.price);
    assign fill_qty_c = qty_min(bid_head_r.quantity, ask_head_r.quantity);

    // Next state and table write-back strobes.
    always_comb begin
        state_d          = state_q;
        bid_head_pop     = 1'b0;
        bid_head_upt     = 1'b0;
        bid_head_upt_tbl = '0;
        ask_head_pop     = 1'b0;
        ask_head_upt     = 1'b0;
        ask_head_upt_tbl = '0;

        case (state_q)
            ST_IDLE:   if (match_en) state_d = ST_CMP;
            ST_CMP:    state_d = cross_c ? ST_EMIT : ST_IDLE;
            ST_EMIT:   if (trade_accept) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_SETTLE;
            ST_SETTLE: state_d = match_en ? ST_CMP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Heads are frozen while busy, so the live head is the entry being written back.
        if (state_q == ST_UPDATE) begin
            if (bid_res_r == '0) begin
                bid_head_pop = 1'b1;
            end else begin
                bid_head_upt              = 1'b1;
                bid_head_upt_tbl          = bid_head_r;
                bid_head_upt_tbl.quantity = bid_res_r;
            end
            if (ask_res_r == '0) begin
                ask_head_pop = 1'b1;
            end else begin
                ask_head_upt              = 1'b1;
                ask_head_upt_tbl          = ask_head_r;
                ask_head_upt_tbl.quantity = ask_res_r;
            end
        end
    end

    // State register, registered handshake/status outputs and trade capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trade_vld_r <= 1'b0;
            busy_r      <= 1'b0;
            trade_r     <= '0;
            bid_res_r   <= '0;
            ask_res_r   <= '0;
            trade_cnt_r <= '0;
        end else begin
            state_q     <= state_d;
            trade_vld_r <= (state_d == ST_EMIT);
            busy_r      <= (state_d != ST_IDLE);

            if ((state_q == ST_CMP) && cross_c) begin
                trade_r.bid_uid  <= bid_head_r.uid;
                trade_r.ask_uid  <= ask_head_r.uid;
                trade_r.quantity <= fill_qty_c;
                trade_r.price    <= ask_head_r.price;
                bid_res_r        <= bid_head_r.quantity - fill_qty_c;
                ask_res_r        <= ask_head_r.quantity - fill_qty_c;
            end

            if ((state_q == ST_UPDATE) && (trade_cnt_r != '1)) begin
                trade_cnt_r <= trade_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ob_match.sv
// Self-checking bench for ob_match: behavioural bid/ask tables, sweep model feeding a trade scoreboard.
module tb_ob_match;
    import ob_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             match_en;
    logic             bid_head_vld_r;
    table_t           bid_head_r;
    logic             ask_head_vld_r;
    table_t           ask_head_r;
    logic             bid_head_pop;
    logic             bid_head_upt;
    table_t           bid_head_upt_tbl;
    logic             ask_head_pop;
    logic             ask_head_upt;
    table_t           ask_head_upt_tbl;
    logic             trade_vld_r;
    trade_t           trade_r;
    logic             trade_accept;
    logic             busy_r;
    logic [CNT_W-1:0] trade_cnt_r;

    ob_match #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .match_en(match_en),
        .bid_head_vld_r(bid_head_vld_r), .bid_head_r(bid_head_r),
        .ask_head_vld_r(ask_head_vld_r), .ask_head_r(ask_head_r),
        .bid_head_pop(bid_head_pop), .bid_head_upt(bid_head_upt), .bid_head_upt_tbl(bid_head_upt_tbl),
        .ask_head_pop(ask_head_pop), .ask_head_upt(ask_head_upt), .ask_head_upt_tbl(ask_head_upt_tbl),
        .trade_vld_r(trade_vld_r), .trade_r(trade_r), .trade_accept(trade_accept),
        .busy_r(busy_r), .trade_cnt_r(trade_cnt_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        price_t    bp;
        quantity_t bq;
        price_t    ap;
        quantity_t aq;
        int        delay;
        bit        exp_trade;
        quantity_t exp_qty;
        price_t    exp_price;
        quantity_t exp_bid_left;
        quantity_t exp_ask_left;
    } vec_t;

    vec_t   vecs[6];
    table_t bid_q[$], ask_q[$], fin_bid[$], fin_ask[$], snap_bid[$], snap_ask[$];
    trade_t exp_q[$];
    int     checks = 0, errors = 0;
    int     accept_delay = 0, vld_cnt = 0, exp_cnt = 0;
    bit     junk_accept = 1'b0, upd_pending = 1'b0, exp_bpop, exp_apop;
    table_t exp_btbl, exp_atbl;
    trade_t hold_trade, last_trade;
    uid_t   next_uid = 16'h0001;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        bid_head_vld_r = (bid_q.size() > 0);
        bid_head_r     = '0;
        if (bid_q.size() > 0) bid_head_r = bid_q[0];
        ask_head_vld_r = (ask_q.size() > 0);
        ask_head_r     = '0;
        if (ask_q.size() > 0) ask_head_r = ask_q[0];
    endtask

    task automatic push_bid(input price_t p, input quantity_t q);
        bid_q.push_back('{uid: next_uid, quantity: q, price: p});
        next_uid++;
    endtask

    task automatic push_ask(input price_t p, input quantity_t q);
        ask_q.push_back('{uid: next_uid, quantity: q, price: p});
        next_uid++;
    endtask

    // Whole-book sweep: expected trade sequence and final book.
    task automatic sweep();
        table_t    b[$], a[$];
        trade_t    t;
        quantity_t q;
        b = bid_q;
        a = ask_q;
        while (b.size() > 0 && a.size() > 0 && b[0].price >= a[0].price) begin
            q = (b[0].quantity < a[0].quantity) ? b[0].quantity : a[0].quantity;
            t = '{bid_uid: b[0].uid, ask_uid: a[0].uid, quantity: q, price: a[0].price};
            exp_q.push_back(t);
            if (b[0].quantity == q) void'(b.pop_front()); else b[0].quantity = b[0].quantity - q;
            if (a[0].quantity == q) void'(a.pop_front()); else a[0].quantity = a[0].quantity - q;
        end
        fin_bid = b;
        fin_ask = a;
    endtask

    // One clock: drive accept, check strobes, apply table updates, score handshakes.
    task automatic tick();
        trade_t t;
        #1;
        if (trade_vld_r === 1'b1) begin
            if (vld_cnt == 0) hold_trade = trade_r;
            else check("trade_stable", trade_r, hold_trade);
            trade_accept = (vld_cnt >= accept_delay);
        end else begin
            trade_accept = junk_accept;
        end

        if (upd_pending) begin
            check("bid_pop", bid_head_pop, exp_bpop);
            check("bid_upt", bid_head_upt, !exp_bpop);
            check("ask_pop", ask_head_pop, exp_apop);
            check("ask_upt", ask_head_upt, !exp_apop);
            if (!exp_bpop) check("bid_upt_tbl", bid_head_upt_tbl, exp_btbl);
            if (!exp_apop) check("ask_upt_tbl", ask_head_upt_tbl, exp_atbl);
            upd_pending = 1'b0;
        end else begin
            check("no_strobe", {bid_head_pop, bid_head_upt, ask_head_pop, ask_head_upt}, 4'b0);
            check("tbl_zero", {bid_head_upt_tbl, ask_head_upt_tbl} == '0, 1'b1);
        end

        if (bid_head_pop === 1'b1 && bid_q.size() > 0) void'(bid_q.pop_front());
        else if (bid_head_upt === 1'b1 && bid_q.size() > 0) bid_q[0] = bid_head_upt_tbl;
        if (ask_head_pop === 1'b1 && ask_q.size() > 0) void'(ask_q.pop_front());
        else if (ask_head_upt === 1'b1 && ask_q.size() > 0) ask_q[0] = ask_head_upt_tbl;

        if (trade_vld_r === 1'b1 && trade_accept) begin
            if (exp_q.size() == 0 || bid_q.size() == 0 || ask_q.size() == 0) begin
                check("unexpected_trade", 1'b1, 1'b0);
            end else begin
                t = exp_q.pop_front();
                check("trade", trade_r, t);
                exp_bpop = (bid_q[0].quantity == t.quantity);
                exp_apop = (ask_q[0].quantity == t.quantity);
                exp_btbl = bid_q[0];
                exp_btbl.quantity = bid_q[0].quantity - t.quantity;
                exp_atbl = ask_q[0];
                exp_atbl.quantity = ask_q[0].quantity - t.quantity;
                upd_pending = 1'b1;
                last_trade  = t;
                if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
            vld_cnt = 0;
        end else if (trade_vld_r === 1'b1) begin
            vld_cnt++;
        end else begin
            vld_cnt = 0;
        end

        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic check_book();
        check("bid_size", bid_q.size(), fin_bid.size());
        check("ask_size", ask_q.size(), fin_ask.size());
        for (int i = 0; i < bid_q.size() && i < fin_bid.size(); i++) check("bid_entry", bid_q[i], fin_bid[i]);
        for (int i = 0; i < ask_q.size() && i < fin_ask.size(); i++) check("ask_entry", ask_q[i], fin_ask[i]);
    endtask

    task automatic run_match(input bit expect_cross);
        int n;
        bit got;
        got = 1'b0;
        refresh();
        sweep();
        match_en = 1'b1;
        tick();
        n = 1;
        check("busy_on_cmp", busy_r, 1'b1);
        while (n < 400) begin
            if (!got && trade_vld_r === 1'b1) begin
                got = 1'b1;
                check("vld_latency", n, 2);
            end
            if (exp_q.size() == 0 && busy_r === 1'b0 && !upd_pending) break;
            tick();
            n++;
        end
        if (n >= 400) check("run_timeout", 1'b1, 1'b0);
        match_en = 1'b0;
        tick();
        tick();
        check("idle_after", busy_r, 1'b0);
        check("exp_drained", exp_q.size(), 0);
        check("cross_seen", got, expect_cross);
        check("trade_cnt", trade_cnt_r, exp_cnt);
        check_book();
    endtask

    initial begin
        vecs[0] = '{16'h0105, 16'd10, 16'h0100, 16'd4, 0, 1'b1, 16'd4, 16'h0100, 16'd6, 16'd0};
        vecs[1] = '{16'h0100, 16'd5,  16'h0100, 16'd5, 0, 1'b1, 16'd5, 16'h0100, 16'd0, 16'd0};
        vecs[2] = '{16'h0099, 16'd5,  16'h0100, 16'd5, 0, 1'b0, 16'd0, 16'h0000, 16'd5, 16'd5};
        vecs[3] = '{16'h0100, 16'd3,  16'h0095, 16'd8, 7, 1'b1, 16'd3, 16'h0095, 16'd0, 16'd5};
        vecs[4] = '{16'h0200, 16'd0,  16'h0150, 16'd5, 0, 1'b1, 16'd0, 16'h0150, 16'd0, 16'd5};
        vecs[5] = '{16'h1000, 16'd7,  16'h0999, 16'd7, 2, 1'b1, 16'd7, 16'h0999, 16'd0, 16'd0};

        rst = 1'b1;
        match_en = 1'b0;
        trade_accept = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", trade_vld_r, 1'b0);
        check("rst_busy", busy_r, 1'b0);
        check("rst_cnt", trade_cnt_r, 0);
        check("rst_trade", trade_r, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single-level vectors.
        for (int i = 0; i < 6; i++) begin
            bid_q.delete();
            ask_q.delete();
            push_bid(vecs[i].bp, vecs[i].bq);
            push_ask(vecs[i].ap, vecs[i].aq);
            accept_delay = vecs[i].delay;
            junk_accept  = (vecs[i].delay > 0);
            run_match(vecs[i].exp_trade);
            if (vecs[i].exp_trade) begin
                check("vec_qty", last_trade.quantity, vecs[i].exp_qty);
                check("vec_price", last_trade.price, vecs[i].exp_price);
            end
            if (vecs[i].exp_bid_left == 0) check("vec_bid_gone", bid_q.size(), 0);
            else check("vec_bid_left", (bid_q.size() == 1) ? bid_q[0].quantity : 16'hFFFF, vecs[i].exp_bid_left);
            if (vecs[i].exp_ask_left == 0) check("vec_ask_gone", ask_q.size(), 0);
            else check("vec_ask_left", (ask_q.size() == 1) ? ask_q[0].quantity : 16'hFFFF, vecs[i].exp_ask_left);
        end
        junk_accept  = 1'b0;
        accept_delay = 0;

        // Equal quantities pop both heads; the next compare sees the new, non-crossing heads.
        bid_q.delete(); ask_q.delete();
        push_bid(16'h0100, 16'd5); push_bid(16'h0090, 16'd2);
        push_ask(16'h0100, 16'd5); push_ask(16'h0095, 16'd1);
        run_match(1'b1);
        check("eq_bid_head", (bid_q.size() == 1) ? bid_q[0].price : 16'hFFFF, 16'h0090);
        check("eq_ask_head", (ask_q.size() == 1) ? ask_q[0].price : 16'hFFFF, 16'h0095);

        // Multi-level sweep of one aggressive bid.
        bid_q.delete(); ask_q.delete();
        push_bid(16'h0110, 16'd12);
        push_ask(16'h0100, 16'd3); push_ask(16'h0102, 16'd4); push_ask(16'h0105, 16'd10);
        accept_delay = 1;
        run_match(1'b1);
        check("sweep_last_qty", last_trade.quantity, 16'd5);
        check("sweep_bid_gone", bid_q.size(), 0);
        check("sweep_ask_left", (ask_q.size() == 1) ? ask_q[0].quantity : 16'hFFFF, 16'd5);
        check("sweep_cnt", trade_cnt_r, 4'd9);

        // Reset while a trade is presented.
        bid_q.delete(); ask_q.delete();
        push_bid(16'h0300, 16'd9);
        push_ask(16'h0250, 16'd4);
        refresh();
        snap_bid = bid_q; snap_ask = ask_q;
        accept_delay = 100;
        sweep();
        match_en = 1'b1;
        begin
            int n;
            n = 0;
            while (trade_vld_r !== 1'b1 && n < 10) begin tick(); n++; end
            check("emit_reached", trade_vld_r, 1'b1);
        end
        match_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("emit_rst_vld", trade_vld_r, 1'b0);
        check("emit_rst_busy", busy_r, 1'b0);
        check("emit_rst_cnt", trade_cnt_r, 0);
        check("emit_rst_trade", trade_r, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        repeat (4) tick();
        fin_bid = snap_bid; fin_ask = snap_ask;
        check_book();
        check("post_rst_busy", busy_r, 1'b0);

        // Counter saturation with many unit fills.
        bid_q.delete(); ask_q.delete();
        for (int i = 0; i < 20; i++) push_bid(16'h0100, 16'd1);
        push_ask(16'h0100, 16'd20);
        accept_delay = 0;
        run_match(1'b1);
        check("cnt_saturated", trade_cnt_r, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
